// File: rtl/instr_parcel_queue.sv
// Instruction parcel queue: buffers fetched 16-bit parcels and presents
// whole (compressed or 32-bit) instructions to the decoder.
module instr_parcel_queue #(
  parameter int RISCV_ARCH  = 64,
  parameter int FETCH_W     = 4,
  parameter int DEPTH       = 16,
  parameter int async_reset = 0
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_flush_pipeline,
  input  logic                     i_f_valid,
  output logic                     o_f_ready,
  input  logic [RISCV_ARCH-1:0]    i_f_pc,
  input  logic [16*FETCH_W-1:0]    i_f_data,
  input  logic                     i_f_load_fault,
  input  logic                     i_f_page_fault_x,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [RISCV_ARCH-1:0]    o_pc,
  output logic [31:0]              o_instr,
  output logic                     o_compressed,
  output logic                     o_instr_load_fault,
  output logic                     o_instr_page_fault_x,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]           r_parcel [DEPTH];
  logic [RISCV_ARCH-1:0] r_pc     [DEPTH];
  logic                  r_lf     [DEPTH];
  logic                  r_pf     [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [RISCV_ARCH-1:0] r_exp_pc;

  logic [AW-1:0]         w_rd1;
  logic [15:0]           w_head;
  logic [15:0]           w_nxt;
  logic                  w_empty;
  logic                  w_head_c;
  logic                  w_head_flt;
  logic                  w_wide;
  logic                  w_push;
  logic                  w_disc;
  logic                  w_pop;
  logic [CW-1:0]         w_pop_n;
  logic [AW-1:0]         w_base;
  logic [AW-1:0]         w_widx [FETCH_W];
  logic [RISCV_ARCH-1:0] w_wpc  [FETCH_W];
  logic                  w_unused;

  assign w_unused = (async_reset != 0);

  assign w_rd1      = r_rd_ptr + AW'(1);
  assign w_head     = r_parcel[r_rd_ptr];
  assign w_nxt      = r_parcel[w_rd1];
  assign w_empty    = (r_count == '0);
  assign w_head_c   = (w_head[1:0] != 2'b11);
  assign w_head_flt = r_lf[r_rd_ptr] | r_pf[r_rd_ptr];
  // A faulted 32-bit head is issued alone so the fault reaches decode early
  assign w_wide     = !w_empty & !w_head_c & !w_head_flt;

  assign o_valid   = !w_empty &
                     (w_head_c | w_head_flt | (r_count >= CW'(2)));
  assign o_f_ready = (r_count <= CW'(DEPTH - FETCH_W));
  assign o_count   = r_count;
  assign o_pc      = r_pc[r_rd_ptr];
  assign o_instr   = w_wide ? {w_nxt, w_head} : {16'h0, w_head};
  assign o_compressed = w_empty | w_head_c;
  assign o_instr_load_fault   = r_lf[r_rd_ptr] | (w_wide & r_lf[w_rd1]);
  assign o_instr_page_fault_x = r_pf[r_rd_ptr] | (w_wide & r_pf[w_rd1]);

  assign w_push  = i_f_valid & o_f_ready;
  assign w_disc  = w_push & !w_empty & (i_f_pc != r_exp_pc);
  assign w_pop   = o_valid & i_ready & !w_disc;
  assign w_pop_n = !w_pop ? CW'(0) : (w_wide ? CW'(2) : CW'(1));
  assign w_base  = w_disc ? '0 : r_wr_ptr;

  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      w_widx[k] = w_base + AW'(k);
      w_wpc[k]  = i_f_pc + RISCV_ARCH'(2 * k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_parcel[i] <= 16'hFFFF;
        r_pc[i]     <= '1;
        r_lf[i]     <= 1'b0;
        r_pf[i]     <= 1'b0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_exp_pc <= '1;
    end else if (i_flush_pipeline) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_exp_pc <= '1;
    end else begin
      if (w_push) begin
        for (int k = 0; k < FETCH_W; k++) begin
          r_parcel[w_widx[k]] <= i_f_data[16*k +: 16];
          r_pc[w_widx[k]]     <= w_wpc[k];
          r_lf[w_widx[k]]     <= i_f_load_fault;
          r_pf[w_widx[k]]     <= i_f_page_fault_x;
        end
        r_exp_pc <= i_f_pc + RISCV_ARCH'(2 * FETCH_W);
      end
      if (w_disc) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= AW'(FETCH_W);
        r_count  <= CW'(FETCH_W);
      end else begin
        r_rd_ptr <= r_rd_ptr + w_pop_n[AW-1:0];
        r_wr_ptr <= w_push ? r_wr_ptr + AW'(FETCH_W) : r_wr_ptr;
        r_count  <= r_count + (w_push ? CW'(FETCH_W) : CW'(0))
                    - w_pop_n;
      end
    end
  end

endmodule

// File: tb/tb_instr_parcel_queue.sv
// Directed bench for instr_parcel_queue (RISCV_ARCH=64, FETCH_W=4,
// DEPTH=16) with hand-computed expectations.
module tb_instr_parcel_queue;

  logic        clk = 1'b0;
  logic        nrst;
  logic        flush;
  logic        f_valid;
  logic        f_ready;
  logic [63:0] f_pc;
  logic [63:0] f_data;
  logic        f_lf;
  logic        f_pf;
  logic        valid;
  logic        ready;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        comp;
  logic        lf;
  logic        pf;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_parcel_queue dut (
    .i_clk                (clk),
    .i_nrst               (nrst),
    .i_flush_pipeline     (flush),
    .i_f_valid            (f_valid),
    .o_f_ready            (f_ready),
    .i_f_pc               (f_pc),
    .i_f_data             (f_data),
    .i_f_load_fault       (f_lf),
    .i_f_page_fault_x     (f_pf),
    .o_valid              (valid),
    .i_ready              (ready),
    .o_pc                 (pc),
    .o_instr              (instr),
    .o_compressed         (comp),
    .o_instr_load_fault   (lf),
    .o_instr_page_fault_x (pf),
    .o_count              (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d,
                      input logic l, input logic p);
    f_valid = 1'b1; f_pc = a; f_data = d; f_lf = l; f_pf = p;
    tick();
    f_valid = 1'b0; f_lf = 1'b0; f_pf = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; ready = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (f_ready !== 1'b1) begin bad++; $display("FAIL rst_fready got=%b exp=1", f_ready); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (pc !== '1) begin bad++; $display("FAIL rst_pc got=%h exp=all ones", pc); end
    total++; if (instr !== 32'h0000FFFF) begin bad++; $display("FAIL rst_instr got=%h exp=0000ffff", instr); end
    total++; if (comp !== 1'b1) begin bad++; $display("FAIL rst_comp got=%b exp=1", comp); end
    total++; if ({lf, pf} !== 2'b00) begin bad++; $display("FAIL rst_faults got=%b exp=00", {lf, pf}); end
    push(64'h8000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    total++; if (count !== 5'd4) begin bad++; $display("FAIL rst_pre_count got=%0d exp=4", count); end
    nrst = 1'b0; f_valid = 1'b1; f_pc = 64'h8008; ready = 1'b1;
    tick();
    nrst = 1'b1; f_valid = 1'b0; ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_push_count got=%0d exp=0", count); end
    total++; if (pc !== '1) begin bad++; $display("FAIL rst_push_pc got=%h exp=all ones", pc); end
    total++; if (instr !== 32'h0000FFFF) begin bad++; $display("FAIL rst_push_instr got=%h exp=0000ffff", instr); end
  endtask

  task automatic test_basic();
    ready = 1'b1;
    push(64'h1000, 64'h0013_0513_4501_0001, 1'b0, 1'b0);
    total++; if (count !== 5'd4) begin bad++; $display("FAIL basic_count got=%0d exp=4", count); end
    total++; if ({valid, comp} !== 2'b11) begin bad++; $display("FAIL basic_v0 got=%b exp=11", {valid, comp}); end
    total++; if (pc !== 64'h1000) begin bad++; $display("FAIL basic_pc0 got=%h exp=1000", pc); end
    total++; if (instr !== 32'h00000001) begin bad++; $display("FAIL basic_i0 got=%h exp=00000001", instr); end
    tick();
    total++; if (pc !== 64'h1002) begin bad++; $display("FAIL basic_pc1 got=%h exp=1002", pc); end
    total++; if (instr !== 32'h00004501) begin bad++; $display("FAIL basic_i1 got=%h exp=00004501", instr); end
    tick();
    total++; if ({valid, comp} !== 2'b10) begin bad++; $display("FAIL basic_v2 got=%b exp=10", {valid, comp}); end
    total++; if (pc !== 64'h1004) begin bad++; $display("FAIL basic_pc2 got=%h exp=1004", pc); end
    total++; if (instr !== 32'h00130513) begin bad++; $display("FAIL basic_i2 got=%h exp=00130513", instr); end
    tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL basic_count_end got=%0d exp=0", count); end
    ready = 1'b0;
  endtask

  task automatic test_straddle();
    do_flush();
    ready = 1'b1;
    push(64'h3000, 64'h0513_0001_0001_0001, 1'b0, 1'b0);
    tick(); tick(); tick();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL strad_gap_count got=%0d exp=1", count); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL strad_gap_valid got=%b exp=0", valid); end
    tick();
    total++; if ({valid, count} !== {1'b0, 5'd1}) begin bad++; $display("FAIL strad_idle got=%b/%0d exp=0/1", valid, count); end
    push(64'h3008, 64'h0001_0001_0001_0013, 1'b1, 1'b0);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL strad_valid got=%b exp=1", valid); end
    total++; if (instr !== 32'h00130513) begin bad++; $display("FAIL strad_instr got=%h exp=00130513", instr); end
    total++; if (pc !== 64'h3006) begin bad++; $display("FAIL strad_pc got=%h exp=3006", pc); end
    total++; if ({comp, lf, pf} !== 3'b010) begin bad++; $display("FAIL strad_flags got=%b exp=010", {comp, lf, pf}); end
    tick();
    total++; if (count !== 5'd3) begin bad++; $display("FAIL strad_pop2 got=%0d exp=3", count); end
    total++; if (pc !== 64'h300A) begin bad++; $display("FAIL strad_pc_next got=%h exp=300a", pc); end
    ready = 1'b0;
  endtask

  task automatic test_fill();
    do_flush();
    ready = 1'b0;
    push(64'h4000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    push(64'h4008, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    push(64'h4010, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    total++; if ({f_ready, count} !== {1'b1, 5'd12}) begin bad++; $display("FAIL fill_12 got=%b/%0d exp=1/12", f_ready, count); end
    push(64'h4018, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    total++; if ({f_ready, count} !== {1'b0, 5'd16}) begin bad++; $display("FAIL fill_16 got=%b/%0d exp=0/16", f_ready, count); end
    ready = 1'b1;
    tick();
    total++; if ({f_ready, count} !== {1'b0, 5'd15}) begin bad++; $display("FAIL fill_15 got=%b/%0d exp=0/15", f_ready, count); end
    push(64'h4020, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    total++; if ({f_ready, count} !== {1'b0, 5'd14}) begin bad++; $display("FAIL fill_blocked got=%b/%0d exp=0/14", f_ready, count); end
    ready = 1'b0;
  endtask

  task automatic test_discontinuity();
    do_flush();
    ready = 1'b0;
    push(64'h5000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    push(64'h5008, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    ready = 1'b1;
    tick(); tick();
    total++; if (count !== 5'd6) begin bad++; $display("FAIL disc_pre got=%0d exp=6", count); end
    push(64'h2000, 64'h0001_0001_0001_4501, 1'b0, 1'b0);
    ready = 1'b0;
    total++; if (count !== 5'd4) begin bad++; $display("FAIL disc_count got=%0d exp=4", count); end
    total++; if (pc !== 64'h2000) begin bad++; $display("FAIL disc_pc got=%h exp=2000", pc); end
    total++; if (instr !== 32'h00004501) begin bad++; $display("FAIL disc_instr got=%h exp=00004501", instr); end
  endtask

  task automatic test_fault();
    do_flush();
    ready = 1'b0;
    push(64'h6000, 64'h0513_0001_0001_0001, 1'b0, 1'b1);
    ready = 1'b1;
    tick(); tick(); tick();
    ready = 1'b0;
    total++; if ({valid, count} !== {1'b1, 5'd1}) begin bad++; $display("FAIL flt_valid got=%b/%0d exp=1/1", valid, count); end
    total++; if ({comp, lf, pf} !== 3'b001) begin bad++; $display("FAIL flt_flags got=%b exp=001", {comp, lf, pf}); end
    total++; if (instr !== 32'h00000513) begin bad++; $display("FAIL flt_instr got=%h exp=00000513", instr); end
    total++; if (pc !== 64'h6006) begin bad++; $display("FAIL flt_pc got=%h exp=6006", pc); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if ({valid, count} !== {1'b0, 5'd0}) begin bad++; $display("FAIL flt_pop1 got=%b/%0d exp=0/0", valid, count); end
  endtask

  task automatic test_flush_push();
    do_flush();
    ready = 1'b0;
    push(64'h7000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    flush = 1'b1; ready = 1'b1;
    push(64'h7008, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    flush = 1'b0; ready = 1'b0;
    total++; if ({valid, f_ready, count} !== {1'b0, 1'b1, 5'd0}) begin bad++; $display("FAIL flush_state got=%b%b/%0d exp=01/0", valid, f_ready, count); end
    push(64'h9000, 64'h0001_0001_0001_4501, 1'b0, 1'b0);
    total++; if (count !== 5'd4) begin bad++; $display("FAIL flush_repush_count got=%0d exp=4", count); end
    total++; if ({valid, pc} !== {1'b1, 64'h9000}) begin bad++; $display("FAIL flush_repush_pc got=%b/%h exp=1/9000", valid, pc); end
    total++; if (instr !== 32'h00004501) begin bad++; $display("FAIL flush_repush_instr got=%h exp=00004501", instr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; flush = 1'b0; f_valid = 1'b0; f_pc = '0;
    f_data = '0; f_lf = 1'b0; f_pf = 1'b0; ready = 1'b0;
    test_reset();
    test_basic();
    test_straddle();
    test_fill();
    test_discontinuity();
    test_fault();
    test_flush_push();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
